// File: rtl/astro_pkg.sv
// ---------------------------------------------------------------------------
// astro_pkg
// Shared types and defaults for the template-match pass sequencer.
//   sched_state_t : top-level sequencer states
//   DEF_*         : default image / window / score geometry
//   coord_t       : window-origin coordinate at default geometry
//   score_t       : match score at default width
// ---------------------------------------------------------------------------
package astro_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_TMPL,
    START_WIN,
    SCAN,
    REPORT
  } sched_state_t;

  localparam int DEF_IMG_W   = 80;
  localparam int DEF_IMG_H   = 80;
  localparam int DEF_WIN     = 16;
  localparam int DEF_SCORE_W = 16;

  typedef logic [6:0]             coord_t;
  typedef logic [DEF_SCORE_W-1:0] score_t;

endpackage

// File: rtl/match_scheduler_if.sv
// ---------------------------------------------------------------------------
// match_scheduler_if
// Groups the host, template-loader, window-streamer and score signals of the
// match scheduler.
//   master : host/datapath side (drives start, abort, tmpl_done, win_ack,
//            win_done, score_valid, score, result_ack)
//   slave  : scheduler side (drives busy, tmpl_start, win_en, result_valid,
//            best_score, best_x, best_y, err)
// ---------------------------------------------------------------------------
interface match_scheduler_if #(
  parameter int SCORE_W = astro_pkg::DEF_SCORE_W,
  parameter int XW      = 7,
  parameter int YW      = 7
);

  logic               start;
  logic               abort;
  logic               busy;
  logic               tmpl_start;
  logic               tmpl_done;
  logic               win_en;
  logic               win_ack;
  logic               win_done;
  logic               score_valid;
  logic [SCORE_W-1:0] score;
  logic               result_valid;
  logic               result_ack;
  logic [SCORE_W-1:0] best_score;
  logic [XW-1:0]      best_x;
  logic [YW-1:0]      best_y;
  logic               err;

  modport master (
    output start, abort, tmpl_done, win_ack, win_done, score_valid, score,
           result_ack,
    input  busy, tmpl_start, win_en, result_valid, best_score, best_x,
           best_y, err
  );

  modport slave (
    input  start, abort, tmpl_done, win_ack, win_done, score_valid, score,
           result_ack,
    output busy, tmpl_start, win_en, result_valid, best_score, best_x,
           best_y, err
  );

endinterface

// File: rtl/best_match_tracker.sv
// ---------------------------------------------------------------------------
// best_match_tracker
// Holds the running minimum score with its window origin, and the raster
// x/y counters that name the window each incoming score belongs to.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : start of a pass; best_score to all-ones, coordinates to 0
//   score_valid : accepted score for the current raster position
//   score       : match score (lower is better)
//   best_score, best_x, best_y : current best result
// ---------------------------------------------------------------------------
module best_match_tracker #(
  parameter int SCORE_W = 16,
  parameter int XW      = 7,
  parameter int YW      = 7,
  parameter int NX      = 65
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               score_valid,
  input  logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] best_score,
  output logic [XW-1:0]      best_x,
  output logic [YW-1:0]      best_y
);

  logic [XW-1:0] x;
  logic [YW-1:0] y;

  // Strict less-than keeps the earliest window when scores tie.
  // x wraps at the last window column and carries into y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_score <= '0;
      best_x     <= '0;
      best_y     <= '0;
      x          <= '0;
      y          <= '0;
    end else if (clear) begin
      best_score <= '1;
      best_x     <= '0;
      best_y     <= '0;
      x          <= '0;
      y          <= '0;
    end else if (score_valid) begin
      if (score < best_score) begin
        best_score <= score;
        best_x     <= x;
        best_y     <= y;
      end
      if (x == XW'(NX - 1)) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/match_scheduler.sv
// ---------------------------------------------------------------------------
// match_scheduler
// Sequences one template-match pass: pulses the template loader, enables the
// window streamer, consumes one score per window in raster order, and holds
// the minimum score and its window origin until the host acknowledges it.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : match_scheduler_if.slave (host, loader, streamer, scores,
//                result outputs)
// ---------------------------------------------------------------------------
module match_scheduler
  import astro_pkg::*;
#(
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H,
  parameter int WIN     = DEF_WIN,
  parameter int SCORE_W = DEF_SCORE_W
) (
  input logic             clk,
  input logic             rst_n,
  match_scheduler_if.slave bus
);

  localparam int NX   = IMG_W - WIN + 1;
  localparam int NY   = IMG_H - WIN + 1;
  localparam int NWIN = NX * NY;
  localparam int CW   = $clog2(NWIN + 1);
  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);
  localparam logic [CW-1:0] NWIN_C = CW'(NWIN);

  sched_state_t  state, state_d;
  logic [CW-1:0] count, count_d;
  logic          done_seen, done_seen_d;
  logic          err_q, err_d;
  logic          tmpl_q, tmpl_d;
  logic          clear;
  logic          upd;
  logic          accept;

  logic [SCORE_W-1:0] best_score;
  logic [XW-1:0]      best_x;
  logic [YW-1:0]      best_y;

  assign accept = bus.score_valid && (count < NWIN_C);

  // State and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      done_seen <= 1'b0;
      err_q     <= 1'b0;
      tmpl_q    <= 1'b0;
    end else begin
      state     <= state_d;
      count     <= count_d;
      done_seen <= done_seen_d;
      err_q     <= err_d;
      tmpl_q    <= tmpl_d;
    end
  end

  // Next-state logic. In SCAN a same-cycle score is counted before win_done
  // is judged. Once win_done is latched the streamer may still drain scores
  // back-to-back; the first score-less cycle with the count still short ends
  // the pass with err.
  always_comb begin
    state_d     = state;
    count_d     = count;
    done_seen_d = done_seen;
    err_d       = err_q;
    tmpl_d      = 1'b0;
    clear       = 1'b0;
    upd         = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          tmpl_d      = 1'b1;
          clear       = 1'b1;
          err_d       = 1'b0;
          count_d     = '0;
          done_seen_d = 1'b0;
          state_d     = LOAD_TMPL;
        end
      end
      LOAD_TMPL: begin
        if (bus.tmpl_done) state_d = START_WIN;
      end
      START_WIN: begin
        if (bus.win_ack) state_d = SCAN;
      end
      SCAN: begin
        if (bus.score_valid) begin
          if (accept) begin
            upd     = 1'b1;
            count_d = count + 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        if (bus.win_done) done_seen_d = 1'b1;
        if ((bus.win_done || done_seen) && (count_d == NWIN_C)) begin
          done_seen_d = 1'b0;
          state_d     = REPORT;
        end else if (done_seen && !bus.score_valid) begin
          err_d       = 1'b1;
          done_seen_d = 1'b0;
          state_d     = REPORT;
        end
      end
      REPORT: begin
        if (bus.result_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // abort wins over every other event but leaves err as it was.
    if (bus.abort && (state != IDLE)) begin
      state_d     = IDLE;
      count_d     = count;
      done_seen_d = 1'b0;
      err_d       = err_q;
      tmpl_d      = 1'b0;
      clear       = 1'b0;
      upd         = 1'b0;
    end
  end

  best_match_tracker #(
    .SCORE_W (SCORE_W),
    .XW      (XW),
    .YW      (YW),
    .NX      (NX)
  ) u_tracker (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .score_valid (upd),
    .score       (bus.score),
    .best_score  (best_score),
    .best_x      (best_x),
    .best_y      (best_y)
  );

  assign bus.busy         = (state != IDLE);
  assign bus.tmpl_start   = tmpl_q;
  assign bus.win_en       = (state == START_WIN);
  assign bus.result_valid = (state == REPORT);
  assign bus.err          = err_q;
  assign bus.best_score   = best_score;
  assign bus.best_x       = best_x;
  assign bus.best_y       = best_y;

endmodule

// File: tb/tb_match_scheduler.sv
// ---------------------------------------------------------------------------
// tb_match_scheduler
// Self-checking bench for match_scheduler on an 18x18 frame with a 16x16
// window (3x3 = 9 window positions).
// ---------------------------------------------------------------------------
module tb_match_scheduler;

  localparam int IMG_W   = 18;
  localparam int IMG_H   = 18;
  localparam int WIN     = 16;
  localparam int SCORE_W = 16;
  localparam int XW      = $clog2(IMG_W);
  localparam int YW      = $clog2(IMG_H);
  localparam int NX      = IMG_W - WIN + 1;
  localparam int NY      = IMG_H - WIN + 1;
  localparam int NWIN    = NX * NY;

  typedef struct {
    string       name;
    int          n;
    logic [15:0] s [12];
    int          done_pos;
    bit          together;
    int          eb;
    int          ex;
    int          ey;
    bit          eerr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs [7];

  match_scheduler_if #(.SCORE_W(SCORE_W), .XW(XW), .YW(YW)) bus ();

  match_scheduler #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .WIN     (WIN),
    .SCORE_W (SCORE_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(input string name, input int n, input int done_pos,
                              input bit together, input int eb, input int ex,
                              input int ey, input bit eerr);
    vec_t v;
    v.name = name;
    v.n = n;
    v.done_pos = done_pos;
    v.together = together;
    v.eb = eb;
    v.ex = ex;
    v.ey = ey;
    v.eerr = eerr;
    for (int i = 0; i < 12; i++) v.s[i] = '0;
    return v;
  endfunction

  // Reference model: the first NWIN scores are the ones that count, the
  // earliest minimum wins, and any count other than NWIN is an error.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int   lim = (v.n < NWIN) ? v.n : NWIN;
    r.eb = 65535;
    r.ex = 0;
    r.ey = 0;
    for (int i = 0; i < lim; i++) begin
      if (int'(v.s[i]) < r.eb) begin
        r.eb = int'(v.s[i]);
        r.ex = i % NX;
        r.ey = i / NX;
      end
    end
    r.eerr = (v.n != NWIN);
    return r;
  endfunction

  task automatic start_pass();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.tmpl_done = 1'b1;
    tick();
    bus.tmpl_done = 1'b0;
    bus.win_ack = 1'b1;
    tick();
    bus.win_ack = 1'b0;
  endtask

  task automatic pulse_done();
    bus.win_done = 1'b1;
    tick();
    bus.win_done = 1'b0;
  endtask

  task automatic wait_report(input string name);
    int k = 0;
    while (!bus.result_valid && k < 20) begin
      tick();
      k++;
    end
    checkOutput({name, "_report"}, 32'(bus.result_valid), 32'd1);
  endtask

  // Runs one full pass for a vector and checks the held result.
  task automatic applyStimulus(input vec_t v, input int gap);
    start_pass();
    for (int i = 0; i < v.n; i++) begin
      repeat ($urandom_range(0, gap)) tick();
      if (!v.together && i == v.done_pos) pulse_done();
      bus.score_valid = 1'b1;
      bus.score = v.s[i];
      bus.win_done = v.together && (i == v.done_pos);
      tick();
      bus.score_valid = 1'b0;
      bus.win_done = 1'b0;
    end
    if (!v.together && v.done_pos >= v.n) pulse_done();
    wait_report(v.name);
    checkOutput({v.name, "_best_score"}, 32'(bus.best_score), 32'(v.eb));
    checkOutput({v.name, "_best_x"}, 32'(bus.best_x), 32'(v.ex));
    checkOutput({v.name, "_best_y"}, 32'(bus.best_y), 32'(v.ey));
    checkOutput({v.name, "_err"}, 32'(bus.err), 32'(v.eerr));
    bus.result_ack = 1'b1;
    tick();
    bus.result_ack = 1'b0;
    checkOutput({v.name, "_rv_drop"}, 32'(bus.result_valid), 32'd0);
    checkOutput({v.name, "_held"}, 32'(bus.best_score), 32'(v.eb));
  endtask

  initial begin
    vec_t rv;

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.tmpl_done = 1'b0;
    bus.win_ack = 1'b0;
    bus.win_done = 1'b0;
    bus.score_valid = 1'b0;
    bus.score = '0;
    bus.result_ack = 1'b0;

    vecs[0] = mk("nominal", 9, 9, 1'b0, 10, 1, 1, 1'b0);
    vecs[0].s = '{16'd50, 16'd40, 16'd40, 16'd70, 16'd10, 16'd10, 16'd90, 16'd30, 16'd20, 16'd0, 16'd0, 16'd0};
    vecs[1] = mk("done_before_last", 9, 8, 1'b0, 1, 2, 2, 1'b0);
    vecs[1].s = '{16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'd0, 16'd0};
    vecs[2] = mk("done_early", 6, 6, 1'b0, 5, 0, 1, 1'b1);
    vecs[2].s = '{16'd30, 16'd20, 16'd25, 16'd5, 16'd60, 16'd70, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    vecs[3] = mk("extra_score", 10, 10, 1'b0, 20, 2, 2, 1'b1);
    vecs[3].s = '{16'd100, 16'd90, 16'd80, 16'd70, 16'd60, 16'd50, 16'd40, 16'd30, 16'd20, 16'd0, 16'd0, 16'd0};
    vecs[4] = mk("ties", 9, 9, 1'b0, 7, 0, 0, 1'b0);
    vecs[4].s = '{16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 16'd0, 16'd0, 16'd0};
    vecs[5] = mk("all_ones", 9, 9, 1'b0, 65535, 0, 0, 1'b0);
    vecs[5].s = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0, 16'd0, 16'd0};
    vecs[6] = mk("done_with_last", 9, 8, 1'b1, 0, 2, 2, 1'b0);
    vecs[6].s = '{16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0};

    // Reset values.
    tick();
    tick();
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_tmpl_start", 32'(bus.tmpl_start), 32'd0);
    checkOutput("rst_win_en", 32'(bus.win_en), 32'd0);
    checkOutput("rst_result_valid", 32'(bus.result_valid), 32'd0);
    checkOutput("rst_best_score", 32'(bus.best_score), 32'd0);
    checkOutput("rst_best_xy", 32'({bus.best_x, bus.best_y}), 32'd0);
    checkOutput("rst_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Handshake timing: tmpl_start only in the cycle after start, win_en held
    // for five cycles until win_ack.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checkOutput("hs_tmpl_start_hi", 32'(bus.tmpl_start), 32'd1);
    checkOutput("hs_busy", 32'(bus.busy), 32'd1);
    checkOutput("hs_clear_best", 32'(bus.best_score), 32'hFFFF);
    tick();
    checkOutput("hs_tmpl_start_lo", 32'(bus.tmpl_start), 32'd0);
    bus.tmpl_done = 1'b1;
    tick();
    bus.tmpl_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("hs_win_en_%0d", i), 32'(bus.win_en), 32'd1);
      if (i == 4) bus.win_ack = 1'b1;
      tick();
    end
    bus.win_ack = 1'b0;
    checkOutput("hs_win_en_drop", 32'(bus.win_en), 32'd0);

    // Abort in SCAN after four scores, then a fresh start reinitialises.
    for (int i = 0; i < 4; i++) begin
      bus.score_valid = 1'b1;
      bus.score = 16'(3 + i);
      tick();
    end
    bus.score_valid = 1'b0;
    checkOutput("ab_pre_best", 32'(bus.best_score), 32'd3);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checkOutput("ab_busy", 32'(bus.busy), 32'd0);
    checkOutput("ab_win_en", 32'(bus.win_en), 32'd0);
    checkOutput("ab_result_valid", 32'(bus.result_valid), 32'd0);
    checkOutput("ab_err", 32'(bus.err), 32'd0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checkOutput("ab_restart_tmpl", 32'(bus.tmpl_start), 32'd1);
    checkOutput("ab_restart_best", 32'(bus.best_score), 32'hFFFF);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checkOutput("ab_load_abort", 32'(bus.busy), 32'd0);

    // Table-driven passes.
    foreach (vecs[k]) applyStimulus(vecs[k], 0);

    // start together with result_ack is ignored; start one cycle later works.
    applyStimulus(vecs[0], 0);
    start_pass();
    for (int i = 0; i < NWIN; i++) begin
      bus.score_valid = 1'b1;
      bus.score = 16'(20 - i);
      tick();
    end
    bus.score_valid = 1'b0;
    pulse_done();
    wait_report("sa");
    bus.start = 1'b1;
    bus.result_ack = 1'b1;
    tick();
    bus.result_ack = 1'b0;
    checkOutput("sa_busy", 32'(bus.busy), 32'd0);
    checkOutput("sa_no_tmpl", 32'(bus.tmpl_start), 32'd0);
    tick();
    bus.start = 1'b0;
    checkOutput("sa_tmpl_later", 32'(bus.tmpl_start), 32'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;

    // Randomised passes against the reference model.
    for (int r = 0; r < 30; r++) begin
      rv = mk($sformatf("rnd%0d", r), $urandom_range(1, 11), 0, 1'b0, 0, 0, 0, 1'b0);
      for (int i = 0; i < 12; i++)
        rv.s[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 40));
      rv.together = 1'($urandom_range(0, 1));
      rv.done_pos = rv.together ? rv.n - 1 : rv.n;
      rv = model(rv);
      applyStimulus(rv, 2);
    end

    // Asynchronous reset mid-pass.
    start_pass();
    bus.score_valid = 1'b1;
    bus.score = 16'd5;
    tick();
    bus.score_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", 32'(bus.busy), 32'd0);
    checkOutput("arst_best", 32'(bus.best_score), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
